decode_stage: RTL
=================

# decode_stage

Parametrised pipelined instruction-decode stage for the five-stage MIPS-style processor. Registers the fetched word in an IF/ID register, splits it into op/rs/rt/rd/funct/imm, reads a built-in register file (with optional write-back bypass), extends the immediate by opcode, detects load-use hazards, and presents a registered ID/EX bundle to execute. It supports stall and flush.

## Interface
Parameters:
- DATA_W, 32: datapath width; legal 16..64.
- REG_COUNT, 32: number of architectural registers; power of two, 2..32. The register index is the low log2(REG_COUNT) bits of each 5-bit field.
- BYPASS, 1: 1 forwards a same-cycle write-back to the read ports; 0 reads stored value only.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- if_valid  in  1  if_instr/if_pc carry an instruction
- if_instr  in  32  fetched instruction word
- if_pc  in  DATA_W  address of if_instr
- id_ready  out  1  stage accepts if_instr this cycle (combinational)
- ex_stall  in  1  execute cannot accept; hold both pipeline registers
- flush  in  1  squash IF/ID and ID/EX contents (branch taken)
- wb_we  in  1  register-file write enable
- wb_addr  in  5  write index
- wb_data  in  DATA_W  write data
- ex_valid  out  1  ID/EX bundle valid
- ex_op  out  6  instr[31:26]
- ex_funct  out  6  instr[5:0]
- ex_rs, ex_rt  out  5  instr[25:21], instr[20:16]
- ex_dest  out  5  destination: rd (instr[15:11]) when op==0, else rt
- ex_rs_val, ex_rt_val  out  DATA_W  register operands
- ex_imm  out  DATA_W  extended immediate
- ex_pc  out  DATA_W  instruction address
- ex_mem_read  out  1  op==0x23 (lw)
- ex_reg_write  out  1  op==0, 0x08–0x0F, or 0x23, and dest≠0

## Operation
- IF/ID register: {valid, instr, pc}. ID/EX register: all ex_* outputs.
- Immediate: ANDI/ORI/XORI (op 0x0C/0x0D/0x0E) zero-extend; LUI (0x0F) = imm<<16, low bits 0 (DATA_W=16: imm); all others sign-extend.
- Register file: REG_COUNT×DATA_W. Index 0 reads 0 and ignores writes. Write occurs on clk edge when wb_we.
- Read bypass (BYPASS=1): if wb_we and wb_addr==read index≠0, the read returns wb_data.
- rt-use: op==0, 0x04 (beq), 0x05 (bne), 0x2B (sw). All ops use rs.
- Hazard = ex_valid & ex_mem_read & ex_dest≠0 & IF/ID valid & (ex_dest==rs | (rt-use & ex_dest==rt)).
- id_ready = !hazard & !ex_stall.
- Per edge, in priority order:
  - rst: all registers and the register file are cleared.
  - flush: IF/ID valid←0 and ID/EX valid←0. Other fields are don't-care. Flush takes priority over ex_stall and hazard.
  - ex_stall: both registers hold.
  - hazard: IF/ID holds. ID/EX loads a bubble (ex_valid=0, ex_mem_read=0, ex_reg_write=0).
  - otherwise: ID/EX ← decode of IF/ID. IF/ID ← {if_valid, if_instr, if_pc}.
- ID/EX loaded from an invalid IF/ID gets ex_valid=0 and ex_mem_read=ex_reg_write=0.

## Timing
- Reset values: all ex_* outputs 0. Register file 0. id_ready=1 unless ex_stall.
- Latency: an instruction accepted at edge N (if_valid & id_ready) appears on ex_* after edge N+1.
- Register read occurs in the cycle before edge N+1. A write at that same edge is seen only via bypass.
- Load-use costs exactly one bubble cycle. The dependent instruction issues the cycle after the load leaves ID/EX.
- Reset asserted mid-stall or mid-hazard clears everything immediately (asynchronous). id_ready returns to 1 the same cycle.
- Simultaneous flush and ex_stall: flush wins and both valids clear.

## Test plan
- Reset: assert rst mid-stream → all ex_* = 0 immediately. Release → first accepted instruction appears 2 edges later.
- Decode/extend: addi $2,$1,-4 (0x2022FFFC) with r1=10 → ex_dest=2, ex_imm=0xFFFFFFFC, ex_rs_val=10. ori $3,$0,0x8001 → ex_imm=0x00008001. lui → 0x80010000.
- Load-use: lw $5,0($1) then add $6,$5,$2 → one cycle with ex_valid=0, id_ready=0. The add follows with ex_rs=5. Variant: dest $0 → no bubble.
- Bypass: wb_we=1, wb_addr=7, wb_data=0xDEADBEEF in the same cycle the decoding instruction reads r7 → ex_rs_val=0xDEADBEEF (BYPASS=1) or the old value (BYPASS=0). Write to r0 → reads 0.
- Stall/flush: hold ex_stall 3 cycles → ex_* stable, id_ready=0. Then flush together with ex_stall → next cycle ex_valid=0 and the IF/ID content is dropped.
- Parameters: DATA_W=16, REG_COUNT=8 → sign-extend to 16 bits, index 9 aliases r1.

Source files
------------

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// decode_stage : IF/ID register, field split, register file with optional
//                write-back bypass, immediate extension, load-use interlock
//                and registered ID/EX bundle.  Revision 1.0
// ============================================================================
module decode_stage #(
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = 32,
    parameter int BYPASS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [DATA_W-1:0] if_pc,
    output logic              id_ready,
    input  logic              ex_stall,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    output logic [5:0]        ex_op,
    output logic [5:0]        ex_funct,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_dest,
    output logic [DATA_W-1:0] ex_rs_val,
    output logic [DATA_W-1:0] ex_rt_val,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc,
    output logic              ex_mem_read,
    output logic              ex_reg_write
);

    localparam int IDX_W = $clog2(REG_COUNT);

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_XORI  = 6'h0E;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    // IF/ID register
    logic              ifid_valid_q, ifid_valid_d;
    logic [31:0]       ifid_instr_q, ifid_instr_d;
    logic [DATA_W-1:0] ifid_pc_q,    ifid_pc_d;

    // ID/EX register
    logic              ex_valid_q,     ex_valid_d;
    logic [5:0]        ex_op_q,        ex_op_d;
    logic [5:0]        ex_funct_q,     ex_funct_d;
    logic [4:0]        ex_rs_q,        ex_rs_d;
    logic [4:0]        ex_rt_q,        ex_rt_d;
    logic [4:0]        ex_dest_q,      ex_dest_d;
    logic [DATA_W-1:0] ex_rs_val_q,    ex_rs_val_d;
    logic [DATA_W-1:0] ex_rt_val_q,    ex_rt_val_d;
    logic [DATA_W-1:0] ex_imm_q,       ex_imm_d;
    logic [DATA_W-1:0] ex_pc_q,        ex_pc_d;
    logic              ex_mem_read_q,  ex_mem_read_d;
    logic              ex_reg_write_q, ex_reg_write_d;

    logic [DATA_W-1:0] rf_q [REG_COUNT];

    logic [5:0]        w_op, w_funct;
    logic [4:0]        w_rs, w_rt, w_rd, w_dest;
    logic [15:0]       w_imm16;
    logic [DATA_W-1:0] w_imm_sext, w_imm_zext, w_imm_lui, w_imm;
    logic [IDX_W-1:0]  w_rs_idx, w_rt_idx, w_wb_idx;
    logic [DATA_W-1:0] w_rs_val, w_rt_val;
    logic              w_rt_use, w_writes_reg, w_hazard;

    assign w_op     = ifid_instr_q[31:26];
    assign w_rs     = ifid_instr_q[25:21];
    assign w_rt     = ifid_instr_q[20:16];
    assign w_rd     = ifid_instr_q[15:11];
    assign w_funct  = ifid_instr_q[5:0];
    assign w_imm16  = ifid_instr_q[15:0];
    assign w_dest   = (w_op == c_OP_RTYPE) ? w_rd : w_rt;

    generate
        if (DATA_W == 16) begin : g_imm_narrow
            assign w_imm_sext = w_imm16;
            assign w_imm_zext = w_imm16;
            assign w_imm_lui  = w_imm16;
        end else begin : g_imm_wide
            logic [DATA_W+15:0] w_lui_full;
            assign w_imm_sext = {{(DATA_W-16){w_imm16[15]}}, w_imm16};
            assign w_imm_zext = {{(DATA_W-16){1'b0}}, w_imm16};
            assign w_lui_full = {{DATA_W{1'b0}}, w_imm16} << 16;
            assign w_imm_lui  = w_lui_full[DATA_W-1:0];
        end
    endgenerate

    always_comb begin
        w_imm = w_imm_sext;
        if (w_op == c_OP_ANDI || w_op == c_OP_ORI || w_op == c_OP_XORI)
            w_imm = w_imm_zext;
        else if (w_op == c_OP_LUI)
            w_imm = w_imm_lui;
    end

    // Only the low index bits select a register, so wider indices alias.
    assign w_rs_idx = w_rs[IDX_W-1:0];
    assign w_rt_idx = w_rt[IDX_W-1:0];
    assign w_wb_idx = wb_addr[IDX_W-1:0];

    always_comb begin
        w_rs_val = rf_q[w_rs_idx];
        w_rt_val = rf_q[w_rt_idx];
        if (BYPASS != 0 && wb_we && w_wb_idx == w_rs_idx)
            w_rs_val = wb_data;
        if (BYPASS != 0 && wb_we && w_wb_idx == w_rt_idx)
            w_rt_val = wb_data;
        if (w_rs_idx == '0)
            w_rs_val = '0;
        if (w_rt_idx == '0)
            w_rt_val = '0;
    end

    assign w_rt_use     = (w_op == c_OP_RTYPE) || (w_op == c_OP_BEQ) ||
                          (w_op == c_OP_BNE)   || (w_op == c_OP_SW);
    assign w_writes_reg = (w_op == c_OP_RTYPE) || (w_op[5:3] == 3'b001) ||
                          (w_op == c_OP_LW);

    assign w_hazard = ex_valid_q && ex_mem_read_q && (ex_dest_q != 5'd0) &&
                      ifid_valid_q &&
                      ((ex_dest_q == w_rs) || (w_rt_use && (ex_dest_q == w_rt)));

    assign id_ready = !w_hazard && !ex_stall;

    always_comb begin
        ifid_valid_d   = ifid_valid_q;
        ifid_instr_d   = ifid_instr_q;
        ifid_pc_d      = ifid_pc_q;
        ex_valid_d     = ex_valid_q;
        ex_op_d        = ex_op_q;
        ex_funct_d     = ex_funct_q;
        ex_rs_d        = ex_rs_q;
        ex_rt_d        = ex_rt_q;
        ex_dest_d      = ex_dest_q;
        ex_rs_val_d    = ex_rs_val_q;
        ex_rt_val_d    = ex_rt_val_q;
        ex_imm_d       = ex_imm_q;
        ex_pc_d        = ex_pc_q;
        ex_mem_read_d  = ex_mem_read_q;
        ex_reg_write_d = ex_reg_write_q;
        if (flush) begin
            ifid_valid_d   = 1'b0;
            ex_valid_d     = 1'b0;
            ex_mem_read_d  = 1'b0;
            ex_reg_write_d = 1'b0;
        end else if (ex_stall) begin
            ex_valid_d     = ex_valid_q;
        end else if (w_hazard) begin
            ex_valid_d     = 1'b0;
            ex_mem_read_d  = 1'b0;
            ex_reg_write_d = 1'b0;
        end else begin
            ex_valid_d     = ifid_valid_q;
            ex_op_d        = w_op;
            ex_funct_d     = w_funct;
            ex_rs_d        = w_rs;
            ex_rt_d        = w_rt;
            ex_dest_d      = w_dest;
            ex_rs_val_d    = w_rs_val;
            ex_rt_val_d    = w_rt_val;
            ex_imm_d       = w_imm;
            ex_pc_d        = ifid_pc_q;
            ex_mem_read_d  = ifid_valid_q && (w_op == c_OP_LW);
            ex_reg_write_d = ifid_valid_q && w_writes_reg && (w_dest != 5'd0);
            ifid_valid_d   = if_valid;
            ifid_instr_d   = if_instr;
            ifid_pc_d      = if_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_valid_q   <= 1'b0;
            ifid_instr_q   <= '0;
            ifid_pc_q      <= '0;
            ex_valid_q     <= 1'b0;
            ex_op_q        <= '0;
            ex_funct_q     <= '0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_dest_q      <= '0;
            ex_rs_val_q    <= '0;
            ex_rt_val_q    <= '0;
            ex_imm_q       <= '0;
            ex_pc_q        <= '0;
            ex_mem_read_q  <= 1'b0;
            ex_reg_write_q <= 1'b0;
        end else begin
            ifid_valid_q   <= ifid_valid_d;
            ifid_instr_q   <= ifid_instr_d;
            ifid_pc_q      <= ifid_pc_d;
            ex_valid_q     <= ex_valid_d;
            ex_op_q        <= ex_op_d;
            ex_funct_q     <= ex_funct_d;
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            ex_dest_q      <= ex_dest_d;
            ex_rs_val_q    <= ex_rs_val_d;
            ex_rt_val_q    <= ex_rt_val_d;
            ex_imm_q       <= ex_imm_d;
            ex_pc_q        <= ex_pc_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_reg_write_q <= ex_reg_write_d;
        end
    end

    // Write-back is independent of stall/flush; r0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++)
                rf_q[i] <= '0;
        end else if (wb_we && w_wb_idx != '0) begin
            rf_q[w_wb_idx] <= wb_data;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_op        = ex_op_q;
    assign ex_funct     = ex_funct_q;
    assign ex_rs        = ex_rs_q;
    assign ex_rt        = ex_rt_q;
    assign ex_dest      = ex_dest_q;
    assign ex_rs_val    = ex_rs_val_q;
    assign ex_rt_val    = ex_rt_val_q;
    assign ex_imm       = ex_imm_q;
    assign ex_pc        = ex_pc_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign ex_reg_write = ex_reg_write_q;

endmodule
`default_nettype wire
